// File: rtl/seg_arith_display_if.sv
// -----------------------------------------------------------------------------
// seg_arith_display_if
// Bundles the switch operands and the multiplexed 7-segment bus of
// seg_arith_display.
//   a_in  [A_W]      operand A (unsigned)
//   b_in  [B_W]      operand B (unsigned)
//   sub              0 = A+B, 1 = A-B
//   seg   [7]        {g,f,e,d,c,b,a}, active-low
//   dp               decimal point, active-low
//   an    [NUM_DIG]  digit enables, active-low, an[NUM_DIG-1] leftmost
//   valid            one-cycle pulse when a new display is committed
// master: the switch side (drives operands); slave: the display engine.
// -----------------------------------------------------------------------------
interface seg_arith_display_if #(
    parameter int A_W     = 10,
    parameter int B_W     = 6,
    parameter int NUM_DIG = 8
);
    logic [A_W-1:0]     a_in;
    logic [B_W-1:0]     b_in;
    logic               sub;
    logic [6:0]         seg;
    logic               dp;
    logic [NUM_DIG-1:0] an;
    logic               valid;

    modport master (output a_in, b_in, sub, input seg, dp, an, valid);
    modport slave  (input a_in, b_in, sub, output seg, dp, an, valid);
endinterface

// File: rtl/seg_arith_display.sv
// -----------------------------------------------------------------------------
// seg_arith_display
// Registers two unsigned operands, adds or subtracts them, converts A, B and
// the result to BCD with a serial shift-add-3 engine and shows the three
// fields on a time-multiplexed, active-low 7-segment bank.
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   seg_arith_display_if.slave (operands in, seg/dp/an/valid out)
// Field layout, left to right: A (A_DIG digits), B (B_DIG), result (R_DIG).
// -----------------------------------------------------------------------------
module seg_arith_display #(
    parameter int A_W      = 10,
    parameter int B_W      = 6,
    parameter int A_DIG    = 3,
    parameter int B_DIG    = 2,
    parameter int R_DIG    = 3,
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seg_arith_display_if.slave bus
);
    localparam int NUM_DIG = A_DIG + B_DIG + R_DIG;
    localparam int RW      = ((A_W > B_W) ? A_W : B_W) + 1;
    // Decimal digits needed for 2^RW-1 (301/1000 ~ log10(2)).
    localparam int ND      = (RW * 301) / 1000 + 1;
    localparam int BCD_W   = 4 * ND;
    localparam int CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW      = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int KW      = $clog2(RW + 1);
    localparam int A_UNITS = B_DIG + R_DIG;
    localparam int B_UNITS = R_DIG;

    // Display register codes beyond the decimal digits 0..9.
    localparam logic [3:0] C_MINUS = 4'd10;
    localparam logic [3:0] C_E     = 4'd11;
    localparam logic [3:0] C_BLANK = 4'd15;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic              load_s, shift_s, commit_s;
    logic [KW-1:0]     bit_cnt_r;
    logic [RW-1:0]     a_ext_s, b_ext_s, res_s;
    logic              neg_s, neg_r;
    logic [RW-1:0]     a_sh_r, b_sh_r, r_sh_r;
    logic [BCD_W-1:0]  a_bcd_r, b_bcd_r, r_bcd_r;
    logic              a_ovf_s, b_ovf_s, r_ovf_s;
    logic [3:0]        disp_nxt_s [NUM_DIG];
    logic [3:0]        disp_r     [NUM_DIG];
    logic [CW-1:0]     cnt_r;
    logic [IW-1:0]     idx_r;
    logic [6:0]        seg_r;
    logic              dp_r;
    logic [NUM_DIG-1:0] an_r;
    logic              valid_r;

    // One double-dabble step: add 3 to every digit above 4, then shift in a bit.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                     input logic bit_in);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < ND; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] > 4'd4) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

    // A value overflows its field when any BCD digit at or above 'dig' is non-zero.
    function automatic logic fld_over(input logic [BCD_W-1:0] bcd, input int dig);
        logic o;
        o = 1'b0;
        for (int i = 0; i < ND; i++) begin
            o = o | ((i >= dig) && (bcd[4*i +: 4] != 4'd0));
        end
        return o;
    endfunction

    // Display code of digit j (0 = units) of a field, with overflow and blanking.
    function automatic logic [3:0] field_code(input logic [BCD_W-1:0] bcd, input int j,
                                              input logic ovf);
        logic       nz_above;
        logic [3:0] d;
        logic [3:0] code;
        nz_above = 1'b0;
        d        = 4'd0;
        for (int k = 0; k < ND; k++) begin
            nz_above = nz_above | ((k > j) && (bcd[4*k +: 4] != 4'd0));
            d        = (k == j) ? bcd[4*k +: 4] : d;
        end
        if (ovf) begin
            code = C_E;
        end else if (BLANK_LZ && (j != 0) && (d == 4'd0) && !nz_above) begin
            code = C_BLANK;
        end else begin
            code = d;
        end
        return code;
    endfunction

    // Segment pattern {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] seg_of(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            C_MINUS: s = 7'b0111111;
            C_E:     s = 7'b0000110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Conversion FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Conversion FSM next-state logic: LOAD -> SHIFT (RW cycles) -> COMMIT
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LOAD:   state_nxt_s = ST_SHIFT;
            ST_SHIFT: begin
                if (bit_cnt_r == KW'(RW - 1)) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_COMMIT: state_nxt_s = ST_LOAD;
            default:   state_nxt_s = ST_LOAD;
        endcase
    end

    // Conversion FSM output decode into datapath strobes
    always_comb begin
        load_s   = 1'b0;
        shift_s  = 1'b0;
        commit_s = 1'b0;
        case (state_r)
            ST_LOAD:   load_s   = 1'b1;
            ST_SHIFT:  shift_s  = 1'b1;
            ST_COMMIT: commit_s = 1'b1;
            default:   load_s   = 1'b0;
        endcase
    end

    // Zero-extended operands and result magnitude/sign for the LOAD cycle
    always_comb begin
        a_ext_s = RW'(bus.a_in);
        b_ext_s = RW'(bus.b_in);
        if (bus.sub && (a_ext_s < b_ext_s)) begin
            neg_s = 1'b1;
            res_s = b_ext_s - a_ext_s;
        end else if (bus.sub) begin
            neg_s = 1'b0;
            res_s = a_ext_s - b_ext_s;
        end else begin
            neg_s = 1'b0;
            res_s = a_ext_s + b_ext_s;
        end
    end

    // Operand capture and three parallel MSB-first double-dabble engines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r <= {KW{1'b0}};
            neg_r     <= 1'b0;
            a_sh_r    <= {RW{1'b0}};
            b_sh_r    <= {RW{1'b0}};
            r_sh_r    <= {RW{1'b0}};
            a_bcd_r   <= {BCD_W{1'b0}};
            b_bcd_r   <= {BCD_W{1'b0}};
            r_bcd_r   <= {BCD_W{1'b0}};
        end else if (load_s) begin
            bit_cnt_r <= {KW{1'b0}};
            neg_r     <= neg_s;
            a_sh_r    <= a_ext_s;
            b_sh_r    <= b_ext_s;
            r_sh_r    <= res_s;
            a_bcd_r   <= {BCD_W{1'b0}};
            b_bcd_r   <= {BCD_W{1'b0}};
            r_bcd_r   <= {BCD_W{1'b0}};
        end else if (shift_s) begin
            bit_cnt_r <= bit_cnt_r + KW'(1);
            a_sh_r    <= {a_sh_r[RW-2:0], 1'b0};
            b_sh_r    <= {b_sh_r[RW-2:0], 1'b0};
            r_sh_r    <= {r_sh_r[RW-2:0], 1'b0};
            a_bcd_r   <= dabble_step(a_bcd_r, a_sh_r[RW-1]);
            b_bcd_r   <= dabble_step(b_bcd_r, b_sh_r[RW-1]);
            r_bcd_r   <= dabble_step(r_bcd_r, r_sh_r[RW-1]);
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Per-digit display codes built from the finished BCD values
    always_comb begin
        a_ovf_s = fld_over(a_bcd_r, A_DIG);
        b_ovf_s = fld_over(b_bcd_r, B_DIG);
        // A negative result gives up its leftmost digit to the sign.
        r_ovf_s = fld_over(r_bcd_r, neg_r ? (R_DIG - 1) : R_DIG);
        for (int i = 0; i < NUM_DIG; i++) begin
            disp_nxt_s[i] = C_BLANK;
        end
        for (int j = 0; j < A_DIG; j++) begin
            disp_nxt_s[A_UNITS + j] = field_code(a_bcd_r, j, a_ovf_s);
        end
        for (int j = 0; j < B_DIG; j++) begin
            disp_nxt_s[B_UNITS + j] = field_code(b_bcd_r, j, b_ovf_s);
        end
        for (int j = 0; j < R_DIG; j++) begin
            if (neg_r && !r_ovf_s && (j == R_DIG - 1)) begin
                disp_nxt_s[j] = C_MINUS;
            end else begin
                disp_nxt_s[j] = field_code(r_bcd_r, j, r_ovf_s);
            end
        end
    end

    // Display registers and valid pulse, updated only at COMMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                disp_r[i] <= C_BLANK;
            end
            valid_r <= 1'b0;
        end else if (commit_s) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                disp_r[i] <= disp_nxt_s[i];
            end
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    // Scan dwell counter and digit index, leftmost digit first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
            idx_r <= IW'(NUM_DIG - 1);
        end else if (cnt_r == CW'(SCAN_DIV - 1)) begin
            cnt_r <= {CW{1'b0}};
            if (idx_r == {IW{1'b0}}) begin
                idx_r <= IW'(NUM_DIG - 1);
            end else begin
                idx_r <= idx_r - IW'(1);
            end
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Registered segment, decimal-point and digit-enable outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= 7'h7F;
            dp_r  <= 1'b1;
            an_r  <= {NUM_DIG{1'b1}};
        end else begin
            seg_r <= seg_of(disp_r[idx_r]);
            dp_r  <= ~((idx_r == IW'(A_UNITS)) || (idx_r == IW'(B_UNITS)));
            an_r  <= ~(NUM_DIG'(1'b1) << idx_r);
        end
    end

    assign bus.seg   = seg_r;
    assign bus.dp    = dp_r;
    assign bus.an    = an_r;
    assign bus.valid = valid_r;

endmodule

// File: tb/tb_seg_arith_display.sv
// -----------------------------------------------------------------------------
// tb_seg_arith_display
// Two instances share the operand switches: dut0 with default fields and
// leading-zero blanking, dut1 with a 4-digit result field and no blanking.
// Stimulus pushes the expected display of every conversion into a per-DUT
// queue; a monitor samples on the falling edge, checks the enabled digit,
// an, dp and valid every cycle, and pops a new expected display on valid.
// -----------------------------------------------------------------------------
module tb_seg_arith_display;
    localparam int A_W      = 10;
    localparam int B_W      = 6;
    localparam int RW       = 11;
    localparam int PER      = RW + 2;
    localparam int SCAN_DIV = 4;
    localparam int MAXD     = 9;
    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_MINUS = 7'b0111111;
    localparam logic [6:0] S_E     = 7'b0000110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   k = 0;
    int   checks = 0;
    int   fails = 0;
    int   cur_a, cur_b;
    bit   cur_s;
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
    logic [7*MAXD-1:0] q0 [$];
    logic [7*MAXD-1:0] q1 [$];
    logic [7*MAXD-1:0] cur [2];

    seg_arith_display_if #(.A_W(A_W), .B_W(B_W), .NUM_DIG(8)) bus0 ();
    seg_arith_display_if #(.A_W(A_W), .B_W(B_W), .NUM_DIG(9)) bus1 ();

    seg_arith_display #(.A_W(A_W), .B_W(B_W), .A_DIG(3), .B_DIG(2), .R_DIG(3),
                        .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    seg_arith_display #(.A_W(A_W), .B_W(B_W), .A_DIG(3), .B_DIG(2), .R_DIG(4),
                        .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial forever #5 clk = ~clk;

    // cycles since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)", name, act, exp, $time, k);
        end
    endtask

    // Segments of digit j of a field holding val in dig digits.
    function automatic logic [6:0] fdig(input int val, input int j, input int dig, input bit blank);
        if (val >= 10 ** dig) return S_E;
        if (blank && j > 0 && val < 10 ** j) return S_BLANK;
        return seg_tab[(val / (10 ** j)) % 10];
    endfunction

    // Whole expected display, digit i at bits [7*i +: 7], index 0 rightmost.
    function automatic logic [7*MAXD-1:0] model(input int a, input int b, input bit s,
                                                 input int rd, input bit blank);
        logic [7*MAXD-1:0] v;
        int  r;
        bit  neg;
        v   = '1;
        neg = s && (a < b);
        r   = s ? (neg ? b - a : a - b) : a + b;
        for (int j = 0; j < 3; j++) v[7*(2 + rd + j) +: 7] = fdig(a, j, 3, blank);
        for (int j = 0; j < 2; j++) v[7*(rd + j) +: 7] = fdig(b, j, 2, blank);
        for (int j = 0; j < rd; j++) begin
            if (!neg)                    v[7*j +: 7] = fdig(r, j, rd, blank);
            else if (r >= 10 ** (rd-1))  v[7*j +: 7] = S_E;
            else if (j == rd - 1)        v[7*j +: 7] = S_MINUS;
            else                         v[7*j +: 7] = fdig(r, j, rd - 1, blank);
        end
        return v;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, " seg0"}, int'(bus0.seg), 'h7F);
        chk({tag, " dp0"}, int'(bus0.dp), 1);
        chk({tag, " an0"}, int'(bus0.an), 'hFF);
        chk({tag, " valid0"}, int'(bus0.valid), 0);
        chk({tag, " seg1"}, int'(bus1.seg), 'h7F);
        chk({tag, " an1"}, int'(bus1.an), 'h1FF);
        chk({tag, " valid1"}, int'(bus1.valid), 0);
    endtask

    task automatic check_dut(input int n, input int nd, input int rd, input logic [6:0] seg,
                             input logic dp, input logic [MAXD-1:0] an, input logic valid);
        int idx;
        logic [MAXD-1:0] ea;
        idx = nd - 1 - (((k - 1) / SCAN_DIV) % nd);
        ea = '1;
        ea[idx] = 1'b0;
        chk($sformatf("an%0d", n), int'(an), int'(ea));
        chk($sformatf("seg%0d digit%0d", n, idx), int'(seg), int'(cur[n][7*idx +: 7]));
        chk($sformatf("dp%0d digit%0d", n, idx), int'(dp), (idx == rd || idx == rd + 2) ? 0 : 1);
        chk($sformatf("valid%0d", n), int'(valid), (k % PER == 0) ? 1 : 0);
        if (valid) begin
            if (n == 0 && q0.size() > 0)      cur[0] = q0.pop_front();
            else if (n == 1 && q1.size() > 0) cur[1] = q1.pop_front();
            else chk($sformatf("queue%0d empty at valid", n), 1, 0);
        end
    endtask

    // Monitor: reset values while rst is high, scanned display otherwise.
    initial begin
        cur[0] = '1;
        cur[1] = '1;
        forever begin
            @(negedge clk);
            if (rst) chk_reset("reset");
            else if (k > 0) begin
                check_dut(0, 8, 3, bus0.seg, bus0.dp, {1'b1, bus0.an}, bus0.valid);
                check_dut(1, 9, 4, bus1.seg, bus1.dp, bus1.an, bus1.valid);
            end
        end
    end

    task automatic set_in(input int a, input int b, input bit s);
        cur_a = a; cur_b = b; cur_s = s;
        bus0.a_in = 10'(a); bus0.b_in = 6'(b); bus0.sub = s;
        bus1.a_in = 10'(a); bus1.b_in = 6'(b); bus1.sub = s;
    endtask

    task automatic push_exp();
        q0.push_back(model(cur_a, cur_b, cur_s, 3, 1'b1));
        q1.push_back(model(cur_a, cur_b, cur_s, 4, 1'b0));
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!bus0.valid && n < 3 * PER) begin
            @(negedge clk);
            n++;
        end
        if (!bus0.valid) chk("wait_valid timeout", 0, 1);
    endtask

    // Wait for a commit, then present the next operands for the following LOAD.
    task automatic step(input int a, input int b, input bit s);
        wait_valid();
        set_in(a, b, s);
        push_exp();
    endtask

    task automatic rand_step();
        int a, b;
        a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1023);
        b = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 63);
        step(a, b, 1'($urandom_range(0, 1)));
    endtask

    int da [9] = '{123, 123, 5, 5, 5, 1023, 1023, 1023, 0};
    int db [9] = '{45, 45, 12, 12, 12, 63, 63, 63, 0};
    bit ds [9] = '{0, 0, 1, 1, 1, 0, 0, 0, 1};

    initial begin
        int n;
        set_in(123, 45, 1'b0);
        repeat (3) @(negedge clk);
        push_exp();
        #1 rst = 1'b0;
        for (int i = 0; i < 9; i++) step(da[i], db[i], ds[i]);
        // operand change during SHIFT is held off until the next LOAD
        step(100, 7, 1'b0);
        repeat (3) @(negedge clk);
        set_in(200, 7, 1'b0);
        step(200, 7, 1'b0);
        step(200, 7, 1'b0);
        for (int i = 0; i < 40; i++) rand_step();
        // asynchronous reset during the dwell of digit 4
        n = 0;
        while (!(k > 0 && (7 - (((k - 1) / SCAN_DIV) % 8)) == 4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("digit4 dwell reached", (n < 100) ? 1 : 0, 1);
        #1 rst = 1'b1;
        #1 chk_reset("async reset");
        q0.delete();
        q1.delete();
        cur[0] = '1;
        cur[1] = '1;
        @(negedge clk);
        set_in(9, 60, 1'b1);
        push_exp();
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) rand_step();
        wait_valid();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
